// File: rtl/mem_ram_arbiter_pkg.sv
// Shared constants, state encoding and small helpers for the data-RAM arbiter.
package mem_ram_arbiter_pkg;

    localparam int MEM_RAM_WIDTH = 12;
    localparam int ARB_N_REQ     = 3;
    localparam int ARB_TIMEOUT   = 15;

    localparam logic [1:0] REQ_CPU  = 2'd0;
    localparam logic [1:0] REQ_TERM = 2'd1;
    localparam logic [1:0] REQ_CMD  = 2'd2;

    typedef enum logic [1:0] {
        ARB_IDLE    = 2'd0,
        ARB_WAIT    = 2'd1,
        ARB_RELEASE = 2'd2
    } arbState_t;

    function automatic logic [ARB_N_REQ-1:0] oneHot(input logic [1:0] idx);
        oneHot = 3'b001 << idx;
    endfunction

endpackage

// File: rtl/mem_ram_arbiter_rr_pick.sv
// Combinational round-robin picker for three requesters; the search starts
// one past the last winner and takes the first set request bit.
module rr_pick_3
    import mem_ram_arbiter_pkg::*;
(
    input  logic [ARB_N_REQ-1:0] i_req,
    input  logic [1:0]           i_last,
    output logic                 o_valid,
    output logic [1:0]           o_idx
);

    logic [1:0] w_order [3];

    always_comb begin
        unique case (i_last)
            REQ_CPU: begin
                w_order[0] = REQ_TERM;
                w_order[1] = REQ_CMD;
                w_order[2] = REQ_CPU;
            end
            REQ_TERM: begin
                w_order[0] = REQ_CMD;
                w_order[1] = REQ_CPU;
                w_order[2] = REQ_TERM;
            end
            default: begin
                w_order[0] = REQ_CPU;
                w_order[1] = REQ_TERM;
                w_order[2] = REQ_CMD;
            end
        endcase
        o_valid = |i_req;
        o_idx   = w_order[0];
        // Scan from lowest priority up so the highest-priority hit wins.
        for (int i = 2; i >= 0; i--) begin
            if (i_req[w_order[i]]) begin
                o_idx = w_order[i];
            end
        end
    end

endmodule

// File: rtl/mem_ram_arbiter.sv
// Shares the single data-RAM port between three requesters: round-robin grant,
// one transaction in flight, finished-flag handshake with a timeout.
module mem_ram_arbiter
    import mem_ram_arbiter_pkg::*;
#(
    parameter int AW      = MEM_RAM_WIDTH,
    parameter int TIMEOUT = ARB_TIMEOUT
) (
    input  logic                   clk,
    input  logic                   clrn,
    input  logic [ARB_N_REQ-1:0]   req,
    input  logic [ARB_N_REQ-1:0]   req_we,
    input  logic [3*AW-1:0]        req_addr,
    input  logic [95:0]            req_wdata,
    output logic [ARB_N_REQ-1:0]   ack,
    output logic [ARB_N_REQ-1:0]   err,
    output logic [31:0]            rdata,
    output logic                   busy,
    output logic [1:0]             grant_id,
    output logic                   mem_re,
    output logic                   mem_we,
    output logic [AW-1:0]          mem_read_addr,
    output logic [AW-1:0]          mem_write_addr,
    output logic [31:0]            mem_write_data,
    input  logic [31:0]            mem_read_data,
    input  logic                   mem_read_finished,
    input  logic                   mem_write_finished
);

    localparam logic [7:0] COUNT_LAST = 8'(TIMEOUT - 1);

    arbState_t              r_state, w_stateNext;
    logic                   r_we, w_weNext;
    logic [AW-1:0]          r_addr, w_addrNext;
    logic [31:0]            r_wdata, w_wdataNext;
    logic [1:0]             r_grantId, w_grantIdNext;
    logic [1:0]             r_lastGrant, w_lastGrantNext;
    logic [7:0]             r_count, w_countNext;
    logic [ARB_N_REQ-1:0]   r_ack, w_ackNext;
    logic [ARB_N_REQ-1:0]   r_err, w_errNext;
    logic [31:0]            r_rdata, w_rdataNext;
    logic                   r_memRe, w_memReNext;
    logic                   r_memWe, w_memWeNext;

    logic                   w_pickValid;
    logic [1:0]             w_pickIdx;
    logic                   w_finished;

    rr_pick_3 u_pick (
        .i_req   (req),
        .i_last  (r_lastGrant),
        .o_valid (w_pickValid),
        .o_idx   (w_pickIdx)
    );

    assign w_finished = r_we ? mem_write_finished : mem_read_finished;

    always_comb begin
        w_stateNext     = r_state;
        w_weNext        = r_we;
        w_addrNext      = r_addr;
        w_wdataNext     = r_wdata;
        w_grantIdNext   = r_grantId;
        w_lastGrantNext = r_lastGrant;
        w_countNext     = r_count;
        w_ackNext       = '0;
        w_errNext       = '0;
        w_rdataNext     = r_rdata;
        w_memReNext     = 1'b0;
        w_memWeNext     = 1'b0;
        unique case (r_state)
            ARB_IDLE: begin
                if (w_pickValid) begin
                    w_stateNext     = ARB_WAIT;
                    w_weNext        = req_we[w_pickIdx];
                    w_addrNext      = req_addr[w_pickIdx*AW +: AW];
                    w_wdataNext     = req_wdata[w_pickIdx*32 +: 32];
                    w_grantIdNext   = w_pickIdx;
                    w_lastGrantNext = w_pickIdx;
                    w_countNext     = '0;
                    w_memReNext     = ~req_we[w_pickIdx];
                    w_memWeNext     = req_we[w_pickIdx];
                end
            end
            ARB_WAIT: begin
                w_memReNext = ~r_we;
                w_memWeNext = r_we;
                if (w_finished) begin
                    w_stateNext = ARB_RELEASE;
                    w_ackNext   = oneHot(r_grantId);
                    w_memReNext = 1'b0;
                    w_memWeNext = 1'b0;
                    if (!r_we) begin
                        w_rdataNext = mem_read_data;
                    end
                end else if (r_count == COUNT_LAST) begin
                    w_stateNext = ARB_RELEASE;
                    w_errNext   = oneHot(r_grantId);
                    w_memReNext = 1'b0;
                    w_memWeNext = 1'b0;
                end else begin
                    w_countNext = r_count + 8'd1;
                end
            end
            ARB_RELEASE: begin
                // Hold off the next issue until the RAM has dropped both flags.
                if (!mem_read_finished && !mem_write_finished) begin
                    w_stateNext = ARB_IDLE;
                end
            end
            default: w_stateNext = ARB_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!clrn) begin
            r_state     <= ARB_IDLE;
            r_we        <= 1'b0;
            r_addr      <= '0;
            r_wdata     <= '0;
            r_grantId   <= REQ_CPU;
            r_lastGrant <= REQ_CMD;
            r_count     <= '0;
            r_ack       <= '0;
            r_err       <= '0;
            r_rdata     <= '0;
            r_memRe     <= 1'b0;
            r_memWe     <= 1'b0;
        end else begin
            r_state     <= w_stateNext;
            r_we        <= w_weNext;
            r_addr      <= w_addrNext;
            r_wdata     <= w_wdataNext;
            r_grantId   <= w_grantIdNext;
            r_lastGrant <= w_lastGrantNext;
            r_count     <= w_countNext;
            r_ack       <= w_ackNext;
            r_err       <= w_errNext;
            r_rdata     <= w_rdataNext;
            r_memRe     <= w_memReNext;
            r_memWe     <= w_memWeNext;
        end
    end

    assign ack            = r_ack;
    assign err            = r_err;
    assign rdata          = r_rdata;
    assign busy           = (r_state != ARB_IDLE);
    assign grant_id       = r_grantId;
    assign mem_re         = r_memRe;
    assign mem_we         = r_memWe;
    assign mem_read_addr  = r_addr;
    assign mem_write_addr = r_addr;
    assign mem_write_data = r_wdata;

endmodule

// File: tb/tb_mem_ram_arbiter.sv
// Random requesters and a latency-randomised RAM stub around the arbiter,
// checked against a transaction-level model of grants, completions and data.
module tb_mem_ram_arbiter;
    import mem_ram_arbiter_pkg::*;

    localparam int AW         = MEM_RAM_WIDTH;
    localparam int TIMEOUT    = 4;
    localparam int NEVER      = 99;
    localparam int NUM_CYCLES = 3000;
    localparam int RESET_AT   = 1500;

    logic              clk = 1'b0;
    logic              clrn;
    logic [2:0]        req, req_we;
    logic [3*AW-1:0]   req_addr;
    logic [95:0]       req_wdata;
    logic [2:0]        ack, err;
    logic [31:0]       rdata;
    logic              busy;
    logic [1:0]        grant_id;
    logic              mem_re, mem_we;
    logic [AW-1:0]     mem_read_addr, mem_write_addr;
    logic [31:0]       mem_write_data, mem_read_data;
    logic              mem_read_finished, mem_write_finished;

    mem_ram_arbiter #(.AW(AW), .TIMEOUT(TIMEOUT)) dut (
        .clk                (clk),
        .clrn               (clrn),
        .req                (req),
        .req_we             (req_we),
        .req_addr           (req_addr),
        .req_wdata          (req_wdata),
        .ack                (ack),
        .err                (err),
        .rdata              (rdata),
        .busy               (busy),
        .grant_id           (grant_id),
        .mem_re             (mem_re),
        .mem_we             (mem_we),
        .mem_read_addr      (mem_read_addr),
        .mem_write_addr     (mem_write_addr),
        .mem_write_data     (mem_write_data),
        .mem_read_data      (mem_read_data),
        .mem_read_finished  (mem_read_finished),
        .mem_write_finished (mem_write_finished)
    );

    always #5 clk = ~clk;

    int          errorCount = 0;
    int          checkCount = 0;

    // Model and stub state
    logic [31:0] refMem  [16];
    logic [31:0] stubMem [16];
    bit          pending [3];
    int          lastGrantM;
    int          activeIdx;
    int          k;
    int          latency;
    int          holdCnt;
    logic        latWe;
    logic [AW-1:0] latAddr;
    logic [31:0] latData;
    logic [31:0] rdataM;
    logic        stubFin;
    logic [2:0]  expAck, expErr;
    logic        expIssue;
    logic        issue;
    bit          resetArm, resetCheck, firstAfterReset;
    int          w;

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checkCount++;
        if (observed !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at %0t",
                     tag, observed, expected, $time);
        end
    endtask

    function automatic int rrModel(input logic [2:0] r, input int last);
        for (int off = 1; off <= 3; off++) begin
            int c = (last + off) % 3;
            if (r[c]) return c;
        end
        return -1;
    endfunction

    task automatic newRequest(input int i);
        pending[i]              = 1'b1;
        req[i]                  = 1'b1;
        req_we[i]               = 1'($urandom_range(0, 1));
        req_addr[i*AW +: AW]    = AW'($urandom);
        req_wdata[i*32 +: 32]   = $urandom;
    endtask

    task automatic applyStimulus(input int reqPercent);
        for (int i = 0; i < 3; i++) begin
            if (i == activeIdx) begin
                // In-flight requester: scramble its inputs or drop req; neither may matter.
                if ($urandom_range(0, 3) == 0) begin
                    req_addr[i*AW +: AW]  = AW'($urandom);
                    req_wdata[i*32 +: 32] = $urandom;
                    req_we[i]             = 1'($urandom_range(0, 1));
                end
                if ($urandom_range(0, 7) == 0) req[i] = 1'b0;
            end else if (!pending[i] && $urandom_range(1, 100) <= reqPercent) begin
                newRequest(i);
            end
        end
    endtask

    initial begin
        clrn = 1'b0;
        req = '0; req_we = '0; req_addr = '0; req_wdata = '0;
        mem_read_data = '0; mem_read_finished = 1'b0; mem_write_finished = 1'b0;
        stubFin = 1'b0; holdCnt = 0;
        for (int i = 0; i < 16; i++) begin
            refMem[i]  = $urandom;
            stubMem[i] = refMem[i];
        end
        for (int i = 0; i < 3; i++) pending[i] = 1'b0;
        lastGrantM = 2; activeIdx = -1; k = 0; latency = 0; rdataM = '0;
        latWe = 1'b0; latAddr = '0; latData = '0;
        resetArm = 1'b0; resetCheck = 1'b0; firstAfterReset = 1'b0;

        repeat (3) @(negedge clk);
        checkOutput("reset_ack", 32'(ack), 0);
        checkOutput("reset_err", 32'(err), 0);
        checkOutput("reset_mem_re", 32'(mem_re), 0);
        checkOutput("reset_mem_we", 32'(mem_we), 0);
        checkOutput("reset_busy", 32'(busy), 0);
        checkOutput("reset_rdata", rdata, 0);
        checkOutput("reset_grant_id", 32'(grant_id), 0);
        checkOutput("reset_addr", 32'(mem_read_addr), 0);
        checkOutput("reset_wdata", mem_write_data, 0);
        clrn = 1'b1;
        // First grant after reset must go to requester 0 when all three ask.
        for (int i = 0; i < 3; i++) newRequest(i);
        firstAfterReset = 1'b1;

        for (int cyc = 0; cyc < NUM_CYCLES; cyc++) begin
            @(negedge clk);
            if (resetCheck) begin
                clrn = 1'b1;
                resetCheck = 1'b0;
                checkOutput("rst_mid_ack", 32'(ack), 0);
                checkOutput("rst_mid_err", 32'(err), 0);
                checkOutput("rst_mid_mem_re", 32'(mem_re), 0);
                checkOutput("rst_mid_mem_we", 32'(mem_we), 0);
                checkOutput("rst_mid_busy", 32'(busy), 0);
                checkOutput("rst_mid_grant_id", 32'(grant_id), 0);
                checkOutput("rst_mid_rdata", rdata, 0);
                activeIdx = -1; lastGrantM = 2; rdataM = '0;
                stubFin = 1'b0; mem_read_finished = 1'b0; mem_write_finished = 1'b0;
                for (int i = 0; i < 3; i++) newRequest(i);
                firstAfterReset = 1'b1;
                continue;
            end
            if (cyc == RESET_AT) resetArm = 1'b1;

            issue = mem_re | mem_we;
            if (activeIdx < 0 && issue) begin
                w = rrModel(req, lastGrantM);
                checkOutput("grant_id", 32'(grant_id), w);
                checkOutput("issue_while_finished", 32'(stubFin), 0);
                if (firstAfterReset) checkOutput("first_after_reset", 32'(grant_id), 0);
                firstAfterReset = 1'b0;
                if (w < 0) w = int'(grant_id);
                activeIdx = w; lastGrantM = w; k = 0;
                latWe   = req_we[w];
                latAddr = req_addr[w*AW +: AW];
                latData = req_wdata[w*32 +: 32];
                latency = ($urandom_range(0, 5) == 0) ? NEVER : int'($urandom_range(0, 2));
                if (resetArm) latency = NEVER;
            end

            if (activeIdx >= 0) begin
                expAck   = (latency != NEVER && k == latency + 1) ? (3'b001 << activeIdx) : 3'b000;
                expErr   = (latency == NEVER && k == TIMEOUT) ? (3'b001 << activeIdx) : 3'b000;
                expIssue = (latency == NEVER) ? (k < TIMEOUT) : (k <= latency);
                checkOutput("ack", 32'(ack), 32'(expAck));
                checkOutput("err", 32'(err), 32'(expErr));
                checkOutput("mem_re", 32'(mem_re), 32'(expIssue && !latWe));
                checkOutput("mem_we", 32'(mem_we), 32'(expIssue && latWe));
                checkOutput("busy_active", 32'(busy), 1);
                if (expIssue) begin
                    checkOutput("mem_read_addr", 32'(mem_read_addr), 32'(latAddr));
                    checkOutput("mem_write_addr", 32'(mem_write_addr), 32'(latAddr));
                    if (latWe) checkOutput("mem_write_data", mem_write_data, latData);
                end
                if (expAck != 0) begin
                    if (latWe) refMem[latAddr[3:0]] = latData;
                    else rdataM = refMem[latAddr[3:0]];
                end
                checkOutput("rdata", rdata, rdataM);

                if (expIssue && k == latency) begin
                    stubFin = 1'b1;
                    holdCnt = $urandom_range(0, 3);
                    if (latWe) stubMem[mem_write_addr[3:0]] = mem_write_data;
                    else mem_read_data = stubMem[mem_read_addr[3:0]];
                end else if (stubFin && !issue) begin
                    if (holdCnt == 0) stubFin = 1'b0;
                    else holdCnt--;
                end

                if (resetArm && k == 1) begin
                    clrn = 1'b0;
                    resetArm = 1'b0;
                    resetCheck = 1'b1;
                end
                if (expAck != 0 || expErr != 0) begin
                    pending[activeIdx] = 1'b0;
                    req[activeIdx] = 1'b0;
                    activeIdx = -1;
                end
                k++;
            end else begin
                checkOutput("idle_ack", 32'(ack), 0);
                checkOutput("idle_err", 32'(err), 0);
                checkOutput("idle_rdata", rdata, rdataM);
                // Busy lingers exactly while the stub still showed its flag.
                checkOutput("release_busy", 32'(busy), 32'(stubFin));
                if (stubFin && !issue) begin
                    if (holdCnt == 0) stubFin = 1'b0;
                    else holdCnt--;
                end
            end

            mem_read_finished  = stubFin & ~latWe;
            mem_write_finished = stubFin & latWe;
            if (!resetCheck) applyStimulus((cyc < RESET_AT) ? 40 : 100);
        end

        $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
        $finish;
    end

endmodule
